// File: rtl/pole_parallel_cfg.sv
// Parallel-form FIR section with a double-buffered coefficient bank and a
// fixed 3-stage multiply / sum / round-and-saturate pipeline.
module pole_parallel_cfg #(
  parameter int DW    = 15,
  parameter int CW    = 14,
  parameter int TAPS  = 6,
  parameter int OW    = 29,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  input  logic                 flush,
  input  logic                 coef_wr,
  input  logic [3:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic signed [OW-1:0] dout,
  output logic                 dout_valid,
  output logic                 sat
);

  localparam int PW   = DW + CW;
  localparam int ACCW = PW + $clog2(TAPS);
  localparam int RW   = ACCW + 1;
  localparam int EW   = ((RW > OW) ? RW : OW) + 1;

  // Handshake: din_valid is a pure qualifier with no ready. A sample is taken
  // on every rising edge where din_valid=1 and flush=0; each taken sample
  // yields exactly one single-cycle dout_valid pulse three edges later.

  logic signed [DW-1:0]   x      [TAPS];
  logic signed [CW-1:0]   shadow [TAPS];
  logic signed [CW-1:0]   active [TAPS];
  logic signed [PW-1:0]   p      [TAPS];
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum_c;
  logic signed [RW-1:0]   r;
  logic signed [EW-1:0]   re;
  logic signed [OW-1:0]   dsat;
  logic                   clip;
  logic                   v_x, v_p, v_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (din_valid) begin
      x[0] <= din;
      for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
    end
  end

  // Swap copies the pre-edge shadow, so a same-cycle write lands in shadow only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (coef_swap) begin
        for (int k = 0; k < TAPS; k++) active[k] <= shadow[k];
      end
      if (coef_wr) begin
        for (int k = 0; k < TAPS; k++) begin
          if (coef_addr == 4'(k)) shadow[k] <= coef_data;
        end
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < TAPS; k++) sum_c = sum_c + ACCW'(p[k]);
  end

  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] RND = RW'(1) <<< (SHIFT - 1);
      assign r = (RW'(acc) + RND) >>> SHIFT;
    end else begin : g_nornd
      assign r = RW'(acc);
    end
  endgenerate

  localparam logic signed [EW-1:0] MAXV = (EW'(1) <<< (OW - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  assign re = EW'(r);

  always_comb begin
    dsat = re[OW-1:0];
    clip = 1'b0;
    if (re > MAXV) begin
      dsat = MAXV[OW-1:0];
      clip = 1'b1;
    end else if (re < MINV) begin
      dsat = MINV[OW-1:0];
      clip = 1'b1;
    end
  end

  // All products of one sample are captured on the same edge from one bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) p[k] <= '0;
      acc        <= '0;
      v_x        <= 1'b0;
      v_p        <= 1'b0;
      v_s        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) p[k] <= PW'(x[k]) * PW'(active[k]);
      acc        <= sum_c;
      v_x        <= din_valid & ~flush;
      v_p        <= v_x;
      v_s        <= v_p;
      dout_valid <= v_s;
      if (v_s) begin
        dout <= dsat;
        sat  <= clip;
      end
    end
  end

endmodule

// File: tb/tb_pole_parallel_cfg.sv
// Bench for pole_parallel_cfg: three parameterisations share one stimulus
// stream and are compared against a window/bank arithmetic reference model.
module tb_pole_parallel_cfg;

  logic               clk;
  logic               rst;
  logic signed [14:0] din;
  logic               din_valid;
  logic               flush;
  logic               coef_wr;
  logic [3:0]         coef_addr;
  logic signed [13:0] coef_data;
  logic               coef_swap;

  logic signed [28:0] dout_a, dout_r;
  logic signed [15:0] dout_s;
  logic               dv_a, dv_s, dv_r;
  logic               sat_a, sat_s, sat_r;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pole_parallel_cfg u_def (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .dout(dout_a), .dout_valid(dv_a), .sat(sat_a)
  );

  pole_parallel_cfg #(.OW(16)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .dout(dout_s), .dout_valid(dv_s), .sat(sat_s)
  );

  pole_parallel_cfg #(.SHIFT(2)) u_rnd (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .dout(dout_r), .dout_valid(dv_r), .sat(sat_r)
  );

  // ---------------- reference model ----------------
  int          cyc;
  int          errors;
  int          checks;
  longint      m_x   [6];
  longint      m_sh  [6];
  longint      m_act [6];
  bit          pending;
  logic [63:0] exp_q[$];
  int          due_q[$];
  longint      ed [3];
  bit          es [3];
  longint      got_a[$];
  longint      got_s[$];
  longint      got_r[$];

  function automatic void ref_out(input longint s, input int shift, input int ow,
                                  output longint d, output bit c);
    longint v;
    longint lim;
    v   = (shift > 0) ? ((s + (64'sd1 <<< (shift - 1))) >>> shift) : s;
    lim = 64'sd1 <<< (ow - 1);
    c   = 1'b1;
    if (v > lim - 1)   d = lim - 1;
    else if (v < -lim) d = -lim;
    else begin
      d = v;
      c = 1'b0;
    end
  endfunction

  // Applies one clock edge to the model using the inputs about to be sampled.
  task automatic model_edge();
    longint s;
    cyc++;
    if (!rst) begin
      for (int k = 0; k < 6; k++) begin
        m_x[k] = 0; m_sh[k] = 0; m_act[k] = 0;
      end
      pending = 1'b0;
      exp_q.delete();
      due_q.delete();
      for (int i = 0; i < 3; i++) begin
        ed[i] = 0; es[i] = 1'b0;
      end
    end else begin
      if (pending) begin
        s = 0;
        for (int k = 0; k < 6; k++) s += m_x[k] * m_act[k];
        exp_q.push_back(s);
        due_q.push_back(cyc + 2);
      end
      pending = din_valid && !flush;
      if (flush) begin
        for (int k = 0; k < 6; k++) m_x[k] = 0;
      end else if (din_valid) begin
        for (int k = 5; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = longint'(din);
      end
      if (coef_swap) begin
        for (int k = 0; k < 6; k++) m_act[k] = m_sh[k];
      end
      if (coef_wr && coef_addr < 4'd6) m_sh[coef_addr] = longint'(coef_data);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_outputs();
    bit     ev;
    longint s;
    ev = (due_q.size() > 0) && (due_q[0] == cyc);
    if (ev) begin
      s = longint'(exp_q.pop_front());
      void'(due_q.pop_front());
      ref_out(s, 0, 29, ed[0], es[0]);
      ref_out(s, 0, 16, ed[1], es[1]);
      ref_out(s, 2, 29, ed[2], es[2]);
    end
    chk("dv_def", longint'(dv_a), longint'(ev));
    chk("dv_sat", longint'(dv_s), longint'(ev));
    chk("dv_rnd", longint'(dv_r), longint'(ev));
    chk("dout_def", longint'(dout_a), ed[0]);
    chk("dout_sat", longint'(dout_s), ed[1]);
    chk("dout_rnd", longint'(dout_r), ed[2]);
    chk("sat_def", longint'(sat_a), longint'(es[0]));
    chk("sat_sat", longint'(sat_s), longint'(es[1]));
    chk("sat_rnd", longint'(sat_r), longint'(es[2]));
    if (dv_a) got_a.push_back(longint'(dout_a));
    if (dv_s) got_s.push_back(longint'(dout_s));
    if (dv_r) got_r.push_back(longint'(dout_r));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; flush = 1'b0; coef_wr = 1'b0; coef_swap = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input int d);
    din = 15'(d); din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    coef_wr = 1'b1; coef_addr = 4'(a); coef_data = 14'(d);
    step();
    coef_wr = 1'b0;
  endtask

  task automatic swap();
    coef_swap = 1'b1;
    step();
    coef_swap = 1'b0;
  endtask

  task automatic load_all(input int d);
    for (int k = 0; k < 6; k++) wr(k, d);
  endtask

  task automatic load_impulse_bank();
    wr(0, 1948); wr(1, 3660); wr(2, 4085); wr(3, 2881); wr(4, 1206); wr(5, 250);
    swap();
  endtask

  task automatic impulse();
    send(1);
    for (int i = 0; i < 5; i++) send(0);
    idle(4);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    longint imp_tab [6];
    imp_tab = '{1948, 3660, 4085, 2881, 1206, 250};
    errors = 0; checks = 0; cyc = 0; pending = 1'b0;
    rst = 1'b0; din = '0; din_valid = 1'b0; flush = 1'b0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ed[i] = 0; es[i] = 1'b0;
    end
    idle(2);
    rst = 1'b1;
    idle(2);

    // impulse response through the default instance
    load_impulse_bank();
    got_a.delete();
    impulse();
    chk("imp_count", longint'(got_a.size()), 6);
    for (int i = 0; i < got_a.size() && i < 6; i++) chk("imp_tap", got_a[i], imp_tab[i]);

    // saturation in both directions on the 16-bit instance
    load_all(8191);
    swap();
    got_s.delete();
    for (int i = 0; i < 6; i++) send(16383);
    for (int i = 0; i < 6; i++) send(-16384);
    idle(4);
    chk("sat_count", longint'(got_s.size()), 12);
    if (got_s.size() == 12) begin
      chk("sat_pos", got_s[5], 32767);
      chk("sat_neg", got_s[11], -32768);
    end
    chk("sat_flag", longint'(sat_s), 1);

    // round-half-up arithmetic shift on the SHIFT=2 instance
    wr(0, 1);
    for (int k = 1; k < 6; k++) wr(k, 0);
    swap();
    got_r.delete();
    send(6); send(-6); send(5);
    idle(4);
    chk("rnd_count", longint'(got_r.size()), 3);
    if (got_r.size() == 3) begin
      chk("rnd_p6", got_r[0], 2);
      chk("rnd_m6", got_r[1], -1);
      chk("rnd_p5", got_r[2], 1);
    end

    // swap mid-stream with steady din=1, then same-cycle write+swap
    load_all(1);
    swap();
    load_all(2);
    din = 15'sd1; din_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (8) step();
    coef_swap = 1'b1;
    step();
    coef_swap = 1'b0;
    repeat (8) step();
    coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 14'sd5; coef_swap = 1'b1;
    step();
    coef_wr = 1'b0; coef_swap = 1'b0;
    repeat (4) step();
    swap();
    repeat (4) step();
    idle(4);

    // gapped valid, flush with valid, then a clean impulse
    for (int i = 0; i < 3; i++) begin
      send($urandom_range(0, 200));
      idle(1);
    end
    din = 15'sd77; din_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; din_valid = 1'b0;
    load_impulse_bank();
    idle(4);
    got_a.delete();
    impulse();
    chk("imp2_count", longint'(got_a.size()), 6);
    for (int i = 0; i < got_a.size() && i < 6; i++) chk("imp2_tap", got_a[i], imp_tab[i]);

    // randomized traffic, including writes to out-of-range addresses
    for (int i = 0; i < 300; i++) begin
      din       = 15'($urandom_range(0, 32767));
      din_valid = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      coef_wr   = ($urandom_range(0, 4) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = 14'($urandom_range(0, 16383));
      coef_swap = ($urandom_range(0, 19) == 0);
      step();
    end

    // reset mid-stream: outputs clear at once, banks come back empty
    for (int i = 0; i < 3; i++) begin
      din = 15'($urandom_range(0, 32767)); din_valid = 1'b1;
      step();
    end
    rst = 1'b0;
    #1;
    chk("rst_dv", longint'({dv_a, dv_s, dv_r}), 0);
    chk("rst_dout_def", longint'(dout_a), 0);
    chk("rst_dout_sat", longint'(dout_s), 0);
    chk("rst_sat_any", longint'({sat_a, sat_s, sat_r}), 0);
    repeat (2) step();
    din_valid = 1'b0;
    rst = 1'b1;
    got_a.delete();
    impulse();
    chk("post_rst_count", longint'(got_a.size()), 6);
    for (int i = 0; i < got_a.size(); i++) chk("post_rst_zero", got_a[i], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pole_parallel_cfg.md
POLE_PARALLEL_CFG -- requirements
Module: pole_parallel_cfg

Interface
REQ-001 SHALL have parameter DW, default 15, meaning signed input sample width.
REQ-002 SHALL have parameter CW, default 14, meaning signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 6, range 2..16, meaning delay-line length and coefficient count.
REQ-004 SHALL have parameter OW, default 29, meaning signed output width.
REQ-005 SHALL have parameter SHIFT, default 0, range 0..DW+CW, meaning right shift applied before output.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port din, input, DW bits signed: input sample.
REQ-009 SHALL have port din_valid, input, 1 bit: din qualifier.
REQ-010 SHALL have port flush, input, 1 bit: synchronous clear of the delay line.
REQ-011 SHALL have port coef_wr, input, 1 bit: shadow coefficient write strobe.
REQ-012 SHALL have port coef_addr, input, 4 bits: shadow coefficient index.
REQ-013 SHALL have port coef_data, input, CW bits signed: coefficient write data.
REQ-014 SHALL have port coef_swap, input, 1 bit: copy every shadow coefficient into the active bank.
REQ-015 SHALL have port dout, output, OW bits signed: filtered sample.
REQ-016 SHALL have port dout_valid, output, 1 bit: dout qualifier.
REQ-017 SHALL have port sat, output, 1 bit: set when the current dout was clipped.

Function
REQ-018 SHALL shift the delay line only on cycles with din_valid=1: x[0]<=din, x[k]<=x[k-1]; otherwise the delay line holds.
REQ-019 SHALL zero the whole delay line when flush=1; flush overrides din_valid in the same cycle, and that din is discarded.
REQ-020 SHALL register the products p[k]=x[k]*c_active[k] (full DW+CW width) in stage 1 every cycle.
REQ-021 SHALL register the sum of all p[k] in stage 2 at accumulator width ACCW=DW+CW+ceil(log2(TAPS)), with no intermediate truncation.
REQ-022 SHALL, in stage 3, form r=(sum + 2^(SHIFT-1))>>>SHIFT when SHIFT>0 (arithmetic shift) and r=sum when SHIFT=0.
REQ-023 SHALL saturate r to [-2^(OW-1), 2^(OW-1)-1] into dout, set sat=1 when clipping occurred, and set sat=0 otherwise.
REQ-024 SHALL assert dout_valid exactly 3 cycles after the cycle in which din_valid=1 was sampled. Latency is fixed and back-to-back valid inputs are accepted every cycle.
REQ-025 SHALL not assert dout_valid for a flushed input. dout and sat SHALL update only with dout_valid=1 and otherwise hold.
REQ-026 SHALL write coef_data to shadow[coef_addr] on coef_wr=1, and SHALL ignore writes with coef_addr>=TAPS.
REQ-027 SHALL copy shadow to active one cycle after coef_swap=1. On simultaneous coef_wr and coef_swap, the copy SHALL use the pre-write shadow value and the write SHALL land in shadow only.
REQ-028 SHALL let samples already in stages 1-3 complete with the coefficients they were multiplied by. Swaps SHALL never produce a mixed-bank product set within one output.

Reset
REQ-029 SHALL, while rst=0, clear the delay line, the pipeline registers, dout, dout_valid and sat to 0 asynchronously.
REQ-030 SHALL clear both coefficient banks to 0 on reset, so that outputs are 0 until coefficients are loaded and swapped.
REQ-031 SHALL discard in-flight samples on reset mid-operation; the first dout_valid after release SHALL be 3 cycles after the first accepted din_valid.

Verification
REQ-032 Impulse: TAPS=6, SHIFT=0; load 1948,3660,4085,2881,1206,250, swap; din=1 then five 0s, all valid -> dout=1948,3660,4085,2881,1206,250 on consecutive valid cycles, sat=0.
REQ-033 Saturation: OW=16, SHIFT=0; all coefficients 8191; din=16383 for 6 valid cycles -> dout=32767 and sat=1. Then din=-16384 for 6 cycles -> dout=-32768 and sat=1.
REQ-034 Rounding: SHIFT=2; c[0]=1 and others 0; din=6 -> dout=2; din=-6 -> dout=-1; din=5 -> dout=1.
REQ-035 Swap mid-stream: swap from all-1s to all-2s on the cycle after a valid input with steady din=1 -> outputs already in the pipeline are 6, and inputs accepted 1 cycle after the swap take effect are 12. Also check simultaneous coef_wr+coef_swap per REQ-027.
REQ-036 Gapped valid and flush: din_valid toggling 1,0,1 -> the delay line holds during gaps and latency stays 3. flush with din_valid=1 -> no dout_valid for that sample, and the next impulse response matches REQ-032.
REQ-037 Reset: rst=0 for 2 cycles mid-stream -> dout=0, dout_valid=0 and sat=0 immediately; the post-release impulse gives all-0 outputs until coefficients are reloaded.
